core_iq: RTL

CORE_IQ -- requirements
Module: core_iq

---
 rtl/core_iq.sv | 99 +++++++++
 1 files changed

// File: rtl/core_iq.sv
// In-order instruction queue between fetch and decode.
// Optional CORE_IQ_BYPASS_EN: empty-queue fetch-to-decode bypass.
module core_iq #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rest,
    input  logic                       flush_en,
    input  logic [31:0]                in_istr,
    input  logic [31:0]                in_pc,
    input  logic                       in_jump,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [31:0]                out_istr,
    output logic [31:0]                out_pc,
    output logic                       out_jump,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [31:0] istr;
        logic [31:0] pc;
        logic        jump;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [CW-1:0] cnt;
    logic          full;
    logic          empty;
    logic          take;
    logic          push;
    logic          pop;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign head  = mem[rptr];

`ifdef CORE_IQ_BYPASS_EN
    logic byp;

    // Empty queue: present the fetch offer directly; consumed if decode takes it.
    assign byp       = empty && in_valid && !flush_en && rest;
    assign take      = byp && out_ready;
    assign out_valid = !empty || byp;
    assign out_istr  = byp ? in_istr : head.istr;
    assign out_pc    = byp ? in_pc   : head.pc;
    assign out_jump  = byp ? in_jump : head.jump;
`else
    assign take      = 1'b0;
    assign out_valid = !empty;
    assign out_istr  = head.istr;
    assign out_pc    = head.pc;
    assign out_jump  = head.jump;
`endif

    assign in_ready = !full;
    assign count    = cnt;

    assign push = in_valid && !full && !flush_en && !take;
    assign pop  = !empty && out_ready && !flush_en;

    // Pointer, occupancy and storage update; flush wins over push/pop.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_en) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= '{istr: in_istr, pc: in_pc, jump: in_jump};
                wptr      <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CW'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule
